debug_halt_unit: RTL and testbench
==================================

# debug_halt_unit

Run-control counterpart of the core's retirement trace path. It accepts debugger commands over a valid/ready handshake and drives a stall request into the pipeline: halt, resume, single-step, and PC breakpoints. It observes the same retirement stream that feeds the trace logic (`i_ok`, `i_pc`, `i_tick`) and returns one response per command, carrying halt state and captured PC or tick.

## Interface
- `NUM_BP`, default 4: number of PC breakpoint slots, 1..8.
- `i_clock`, in, 1: clock.
- `i_reset`, in, 1: reset, synchronous, active-low.
- `i_cmdValid`, in, 1: command valid.
- `o_cmdReady`, out, 1: command accepted when high together with `i_cmdValid`.
- `i_cmd`, in, 3: `DbgCmd` opcode.
- `i_cmdIndex`, in, 3: breakpoint slot for SETBP/CLRBP.
- `i_cmdAddr`, in, 32 (`InstAddr`): breakpoint address for SETBP.
- `o_rspValid`, out, 1: response valid.
- `i_rspReady`, in, 1: response consumed when high together with `o_rspValid`.
- `o_rspStatus`, out, 4: {err, halted, cause[1:0]}.
- `o_rspData`, out, 32: command result.
- `i_ok`, in, 1: an instruction retired this cycle.
- `i_pc`, in, 32 (`InstAddr`): PC of the retired instruction.
- `i_tick`, in, 32 (`int`): tick of the retired instruction.
- `o_halt`, out, 1: stall request to the pipeline (registered).
- `o_halted`, out, 1: unit is in HALTED.

## Operation
- Commands: NOP=0, HALT=1, RESUME=2, STEP=3, SETBP=4, CLRBP=5, STATUS=6, READPC=7.
- Causes: NONE=0, REQ=1, STEP=2, BREAK=3.
- FSM states:
  - **RUN**: `o_halt`=0.
  - **STEP**: `o_halt`=0, waiting for exactly one retirement.
  - **HALTED**: `o_halt`=1.
- RUN → HALTED on an accepted HALT (cause REQ).
- RUN → HALTED on `i_ok` with `i_pc` equal to an enabled breakpoint (cause BREAK).
- HALTED → RUN on RESUME.
- HALTED → STEP on STEP.
- STEP → HALTED on the first `i_ok` (cause STEP). If that PC also matches a breakpoint, the cause is BREAK instead.
- Every `i_ok` in any state updates `lastPc`/`lastTick`. This includes pipeline-drain retirements while HALTED. Breakpoint matching is disabled in HALTED.
- Response data:
  - HALT: 0.
  - RESUME: 0.
  - STEP: 0.
  - SETBP: slot index.
  - CLRBP: slot index.
  - STATUS: `lastTick`.
  - READPC: `lastPc`.
- The err bit is set for:
  - RESUME or STEP while not HALTED;
  - HALT while HALTED;
  - SETBP or CLRBP with `i_cmdIndex` ≥ `NUM_BP`.
- An erroring command changes no state.
- SETBP writes the address and sets the enable bit. CLRBP clears the enable bit.
- Response status reflects the state after the command takes effect.

## Timing
- Reset values:
  - `o_halt`=0, `o_halted`=0, state RUN.
  - All breakpoints disabled, addresses 0.
  - `lastPc`=0, `lastTick`=0, cause NONE.
  - `o_rspValid`=0, `o_rspStatus`=0, `o_rspData`=0.
  - `o_cmdReady`=1.
- `o_cmdReady` = !`o_rspValid` | `i_rspReady`. The response register is single-entry, and back-to-back commands are sustainable at 1 per cycle.
- A command accepted at edge N gives:
  - `o_rspValid`=1 from edge N+1;
  - `o_halt`/`o_halted` updated at edge N+1.
- Breakpoint hit: `i_ok`&match sampled at edge N gives `o_halt`=1 at N+1. The matching instruction has retired.
- In the same cycle, an accepted HALT in RUN and a breakpoint hit both lead to HALTED. Cause is BREAK, and the HALT response has err=0.
- In the same cycle, a command and `i_ok` are both applied. `lastPc` updates before READPC/STATUS data is sampled, so the response returns the new value.
- `o_rspData`/`o_rspStatus` are held stable while `o_rspValid`&!`i_rspReady`.
- Reset asserted mid-operation (any state, pending response) returns all outputs to reset values at the next edge. The pending response is dropped.

## Structure
- Shared package `Types` gets:
  - `DbgCmd` enum (3 bit);
  - `DbgCause` enum (2 bit);
  - `DbgStatus` packed struct {err, halted, cause}.
- Sub-module `breakpoint_match`:
  - `NUM_BP` address/enable registers, write port (index, addr, set/clr);
  - combinational hit = OR over enabled(addr == `i_pc`).
- FSM, response register and `lastPc`/`lastTick` live in `debug_halt_unit`.

## Test plan
- **Reset:** hold `i_reset`=0 3 cycles → `o_halt`=0, `o_halted`=0, `o_rspValid`=0, `o_cmdReady`=1.
- **Breakpoint:** SETBP idx 1 addr 0x00000040, then retire 0x3C, 0x40 → `o_halt`=1 the cycle after 0x40. READPC returns 0x40, status {0,1,BREAK}.
- **Single step:**
  - from HALTED, STEP → `o_halt`=0 until next `i_ok` (pc 0x44, tick 17), then `o_halt`=1;
  - STATUS returns 17, cause STEP.
- **Errors:**
  - RESUME while RUN → err=1, state unchanged;
  - SETBP idx 5 with `NUM_BP`=4 → err=1, no match on that address.
- **Backpressure:** HALT then READPC with `i_rspReady`=0 for 4 cycles → `o_cmdReady`=0, first response held stable, second accepted the cycle after `i_rspReady`=1.
- **Simultaneous events:** HALT accepted in the same cycle as a breakpoint hit at 0x80 → cause BREAK, err=0. Reset asserted while HALTED with a pending response → all reset values at the next edge.

Source files
------------

// File: rtl/debug_halt_unit_pkg.sv
// Shared run-control types: command opcodes, halt causes, response status layout.
package Types;

   typedef logic [31:0] InstAddr;

   typedef enum logic [2:0] {
      CMD_NOP    = 3'd0,
      CMD_HALT   = 3'd1,
      CMD_RESUME = 3'd2,
      CMD_STEP   = 3'd3,
      CMD_SETBP  = 3'd4,
      CMD_CLRBP  = 3'd5,
      CMD_STATUS = 3'd6,
      CMD_READPC = 3'd7
   } DbgCmd;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'd0,
      CAUSE_REQ   = 2'd1,
      CAUSE_STEP  = 2'd2,
      CAUSE_BREAK = 2'd3
   } DbgCause;

   typedef struct packed {
      logic    err;
      logic    halted;
      DbgCause cause;
   } DbgStatus;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STEP   = 2'd1,
      ST_HALTED = 2'd2
   } RunState;

endpackage

// File: rtl/debug_halt_unit_match.sv
// PC breakpoint slots: address/enable registers plus a combinational hit on the retiring PC.
module breakpoint_match
   import Types::*;
#(
   parameter int NUM_BP = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_wrEn,
   input  logic        i_wrSet,
   input  logic [2:0]  i_wrIndex,
   input  logic [31:0] i_wrAddr,
   input  logic [31:0] i_pc,
   output logic        o_hit
);

   InstAddr           bpAddr [NUM_BP];
   logic [NUM_BP-1:0] bpEnable;

   // Slot writes: SETBP loads the address and enables, CLRBP only disables (address kept).
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         for (int i = 0; i < NUM_BP; i++) begin
            bpAddr[i]   <= '0;
            bpEnable[i] <= 1'b0;
         end
      end else if (i_wrEn) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (i_wrIndex == 3'(i)) begin
               if (i_wrSet) begin
                  bpAddr[i] <= i_wrAddr;
               end
               bpEnable[i] <= i_wrSet;
            end
         end
      end
   end

   // Hit is the OR over all enabled slots whose address equals the retiring PC.
   always_comb begin
      o_hit = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bpEnable[i] && (bpAddr[i] == i_pc)) begin
            o_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/debug_halt_unit.sv
// Debug run-control: command/response handshake, halt/step/breakpoint FSM and retirement capture.
module debug_halt_unit
   import Types::*;
#(
   parameter int NUM_BP = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_cmdValid,
   output logic        o_cmdReady,
   input  logic [2:0]  i_cmd,
   input  logic [2:0]  i_cmdIndex,
   input  logic [31:0] i_cmdAddr,
   output logic        o_rspValid,
   input  logic        i_rspReady,
   output logic [3:0]  o_rspStatus,
   output logic [31:0] o_rspData,
   input  logic        i_ok,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_tick,
   output logic        o_halt,
   output logic        o_halted
);

   RunState     state, nextState;
   DbgCause     cause, nextCause;
   InstAddr     lastPc;
   logic [31:0] lastTick;
   logic        haltReg;
   logic        rspValid;
   DbgStatus    rspStatus, rspStatusNext;
   logic [31:0] rspData, rspDataNext;
   DbgCmd       cmd;
   logic        cmdAccept, cmdErr, indexOk, bpHitRaw, bpHit, bpWrEn;

   assign cmd        = DbgCmd'(i_cmd);
   assign o_cmdReady = !rspValid || i_rspReady;
   assign cmdAccept  = i_cmdValid && o_cmdReady;
   assign indexOk    = int'(i_cmdIndex) < NUM_BP;
   assign bpWrEn     = cmdAccept && indexOk && ((cmd == CMD_SETBP) || (cmd == CMD_CLRBP));
   assign bpHit      = i_ok && bpHitRaw && (state != ST_HALTED);

   breakpoint_match #(
      .NUM_BP (NUM_BP)
   ) u_match (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_wrEn    (bpWrEn),
      .i_wrSet   (cmd == CMD_SETBP),
      .i_wrIndex (i_cmdIndex),
      .i_wrAddr  (i_cmdAddr),
      .i_pc      (i_pc),
      .o_hit     (bpHitRaw)
   );

   // Next state/cause: retirement events first, then the accepted command; a breakpoint
   // hit in the same cycle as HALT keeps cause BREAK. Also builds the response payload.
   always_comb begin
      nextState   = state;
      nextCause   = cause;
      cmdErr      = 1'b0;
      rspDataNext = '0;
      case (state)
         ST_RUN: begin
            if (bpHit) begin
               nextState = ST_HALTED;
               nextCause = CAUSE_BREAK;
            end
         end
         ST_STEP: begin
            if (i_ok) begin
               nextState = ST_HALTED;
               nextCause = bpHit ? CAUSE_BREAK : CAUSE_STEP;
            end
         end
         default: ;
      endcase
      if (cmdAccept) begin
         case (cmd)
            CMD_HALT: begin
               if (state == ST_HALTED) begin
                  cmdErr = 1'b1;
               end else if (nextState != ST_HALTED) begin
                  nextState = ST_HALTED;
                  nextCause = CAUSE_REQ;
               end
            end
            CMD_RESUME: begin
               if (state != ST_HALTED) begin
                  cmdErr = 1'b1;
               end else begin
                  nextState = ST_RUN;
                  nextCause = CAUSE_NONE;
               end
            end
            CMD_STEP: begin
               if (state != ST_HALTED) begin
                  cmdErr = 1'b1;
               end else begin
                  nextState = ST_STEP;
                  nextCause = CAUSE_NONE;
               end
            end
            CMD_SETBP, CMD_CLRBP: begin
               cmdErr      = !indexOk;
               rspDataNext = {29'd0, i_cmdIndex};
            end
            CMD_STATUS: rspDataNext = i_ok ? i_tick : lastTick;
            CMD_READPC: rspDataNext = i_ok ? i_pc : lastPc;
            default: ;
         endcase
      end
      rspStatusNext = '{err: cmdErr, halted: (nextState == ST_HALTED), cause: nextCause};
   end

   // Run-control state, cause and the registered stall request.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state   <= ST_RUN;
         cause   <= CAUSE_NONE;
         haltReg <= 1'b0;
      end else begin
         state   <= nextState;
         cause   <= nextCause;
         haltReg <= (nextState == ST_HALTED);
      end
   end

   // Capture every retirement, including drain retirements while halted.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         lastPc   <= '0;
         lastTick <= '0;
      end else if (i_ok) begin
         lastPc   <= i_pc;
         lastTick <= i_tick;
      end
   end

   // Single-entry response register; payload only changes when a new command is accepted.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         rspValid  <= 1'b0;
         rspStatus <= '0;
         rspData   <= '0;
      end else if (cmdAccept) begin
         rspValid  <= 1'b1;
         rspStatus <= rspStatusNext;
         rspData   <= rspDataNext;
      end else if (i_rspReady) begin
         rspValid  <= 1'b0;
      end
   end

   assign o_rspValid  = rspValid;
   assign o_rspStatus = rspStatus;
   assign o_rspData   = rspData;
   assign o_halt      = haltReg;
   assign o_halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_debug_halt_unit.sv
// Table-driven bench for debug_halt_unit plus hand-written backpressure and reset sequences.
module tb_debug_halt_unit;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_cmdValid;
   logic        o_cmdReady;
   logic [2:0]  i_cmd;
   logic [2:0]  i_cmdIndex;
   logic [31:0] i_cmdAddr;
   logic        o_rspValid;
   logic        i_rspReady;
   logic [3:0]  o_rspStatus;
   logic [31:0] o_rspData;
   logic        i_ok;
   logic [31:0] i_pc;
   logic [31:0] i_tick;
   logic        o_halt;
   logic        o_halted;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RESUME = 3'd2, STEP = 3'd3,
                          SETBP = 3'd4, CLRBP = 3'd5, STATUS = 3'd6, READPC = 3'd7;
   localparam logic [3:0] FULL = 4'b1111, NOCAUSE = 4'b1100;

   typedef struct {
      logic        cmdValid;
      logic [2:0]  cmd;
      logic [2:0]  idx;
      logic [31:0] addr;
      logic        ok;
      logic [31:0] pc;
      logic [31:0] tick;
      logic        expRspValid;
      logic [3:0]  expStatus;
      logic [3:0]  statusMask;
      logic [31:0] expData;
      logic        expHalt;
   } Vec;

   Vec vecs[$];

   debug_halt_unit #(.NUM_BP(4)) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_cmdValid  (i_cmdValid),
      .o_cmdReady  (o_cmdReady),
      .i_cmd       (i_cmd),
      .i_cmdIndex  (i_cmdIndex),
      .i_cmdAddr   (i_cmdAddr),
      .o_rspValid  (o_rspValid),
      .i_rspReady  (i_rspReady),
      .o_rspStatus (o_rspStatus),
      .o_rspData   (o_rspData),
      .i_ok        (i_ok),
      .i_pc        (i_pc),
      .i_tick      (i_tick),
      .o_halt      (o_halt),
      .o_halted    (o_halted)
   );

   // Free-running clock, period 10.
   always #5 i_clock = ~i_clock;

   function automatic Vec mkVec(logic cv, logic [2:0] c, logic [2:0] ix, logic [31:0] ad,
                                logic ok, logic [31:0] pc, logic [31:0] tk,
                                logic erv, logic [3:0] est, logic [3:0] msk,
                                logic [31:0] edat, logic eh);
      Vec v;
      v.cmdValid = cv; v.cmd = c; v.idx = ix; v.addr = ad;
      v.ok = ok; v.pc = pc; v.tick = tk;
      v.expRspValid = erv; v.expStatus = est; v.statusMask = msk;
      v.expData = edat; v.expHalt = eh;
      return v;
   endfunction

   task automatic applyStimulus(input logic cv, input logic [2:0] c, input logic [2:0] ix,
                                input logic [31:0] ad, input logic ok, input logic [31:0] pc,
                                input logic [31:0] tk, input logic rr);
      i_cmdValid = cv; i_cmd = c; i_cmdIndex = ix; i_cmdAddr = ad;
      i_ok = ok; i_pc = pc; i_tick = tk; i_rspReady = rr;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic stepCycle();
      @(posedge i_clock);
      #1;
   endtask

   initial begin
      // Breakpoint flow, single step, errors, simultaneous HALT+hit, drain while halted.
      vecs.push_back(mkVec(1, SETBP,  1, 32'h40, 0, 0,      0,  1, 4'b0000, FULL,    1,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     1, 32'h3C, 10, 0, 4'b0000, FULL,    0,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     1, 32'h40, 11, 0, 4'b0000, FULL,    0,      1));
      vecs.push_back(mkVec(1, READPC, 0, 0,     0, 0,      0,  1, 4'b0111, FULL,    32'h40, 1));
      vecs.push_back(mkVec(1, STEP,   0, 0,     0, 0,      0,  1, 4'b0000, NOCAUSE, 0,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     0, 0,      0,  0, 4'b0000, FULL,    0,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     1, 32'h44, 17, 0, 4'b0000, FULL,    0,      1));
      vecs.push_back(mkVec(1, STATUS, 0, 0,     0, 0,      0,  1, 4'b0110, FULL,    17,     1));
      vecs.push_back(mkVec(1, RESUME, 0, 0,     0, 0,      0,  1, 4'b0000, NOCAUSE, 0,      0));
      vecs.push_back(mkVec(1, RESUME, 0, 0,     0, 0,      0,  1, 4'b1000, NOCAUSE, 0,      0));
      vecs.push_back(mkVec(1, SETBP,  5, 32'h60, 0, 0,     0,  1, 4'b1000, NOCAUSE, 5,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     1, 32'h60, 20, 0, 4'b0000, FULL,    0,      0));
      vecs.push_back(mkVec(1, SETBP,  2, 32'h80, 0, 0,     0,  1, 4'b0000, NOCAUSE, 2,      0));
      vecs.push_back(mkVec(1, HALT,   0, 0,     1, 32'h80, 21, 1, 4'b0111, FULL,    0,      1));
      vecs.push_back(mkVec(1, HALT,   0, 0,     0, 0,      0,  1, 4'b1111, FULL,    0,      1));
      vecs.push_back(mkVec(1, READPC, 0, 0,     1, 32'h40, 22, 1, 4'b0111, FULL,    32'h40, 1));
      vecs.push_back(mkVec(1, CLRBP,  1, 0,     0, 0,      0,  1, 4'b0111, FULL,    1,      1));
      vecs.push_back(mkVec(1, RESUME, 0, 0,     0, 0,      0,  1, 4'b0000, NOCAUSE, 0,      0));
      vecs.push_back(mkVec(0, NOP,    0, 0,     1, 32'h40, 23, 0, 4'b0000, FULL,    0,      0));
      vecs.push_back(mkVec(1, NOP,    0, 0,     0, 0,      0,  1, 4'b0000, NOCAUSE, 0,      0));
      vecs.push_back(mkVec(1, STATUS, 0, 0,     0, 0,      0,  1, 4'b0000, NOCAUSE, 23,     0));

      // Reset held for three cycles.
      i_reset = 1'b0;
      applyStimulus(0, NOP, 0, 0, 0, 0, 0, 1);
      repeat (3) stepCycle();
      checkOutput("reset_halt",     32'(o_halt),      0);
      checkOutput("reset_halted",   32'(o_halted),    0);
      checkOutput("reset_rspValid", 32'(o_rspValid),  0);
      checkOutput("reset_cmdReady", 32'(o_cmdReady),  1);
      checkOutput("reset_status",   32'(o_rspStatus), 0);
      checkOutput("reset_data",     o_rspData,        0);
      i_reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].cmdValid, vecs[i].cmd, vecs[i].idx, vecs[i].addr,
                       vecs[i].ok, vecs[i].pc, vecs[i].tick, 1'b1);
         #1;
         checkOutput($sformatf("v%0d_cmdReady", i), 32'(o_cmdReady), 1);
         stepCycle();
         checkOutput($sformatf("v%0d_rspValid", i), 32'(o_rspValid), 32'(vecs[i].expRspValid));
         checkOutput($sformatf("v%0d_halt", i),     32'(o_halt),     32'(vecs[i].expHalt));
         checkOutput($sformatf("v%0d_halted", i),   32'(o_halted),   32'(vecs[i].expHalt));
         if (vecs[i].expRspValid) begin
            checkOutput($sformatf("v%0d_status", i), 32'(o_rspStatus & vecs[i].statusMask),
                        32'(vecs[i].expStatus & vecs[i].statusMask));
            checkOutput($sformatf("v%0d_data", i), o_rspData, vecs[i].expData);
         end
      end

      // Backpressure: drain, then HALT with the consumer stalled.
      applyStimulus(0, NOP, 0, 0, 0, 0, 0, 1);
      stepCycle();
      checkOutput("bp_drain_rspValid", 32'(o_rspValid), 0);
      applyStimulus(1, HALT, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("bp_halt_cmdReady", 32'(o_cmdReady), 1);
      stepCycle();
      checkOutput("bp_halt_rspValid", 32'(o_rspValid),  1);
      checkOutput("bp_halt_status",   32'(o_rspStatus), 32'(4'b0101));
      checkOutput("bp_halt_halt",     32'(o_halt),      1);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1, READPC, 0, 0, 0, 0, 0, 0);
         #1;
         checkOutput($sformatf("bp_stall%0d_cmdReady", c), 32'(o_cmdReady), 0);
         stepCycle();
         checkOutput($sformatf("bp_stall%0d_rspValid", c), 32'(o_rspValid),  1);
         checkOutput($sformatf("bp_stall%0d_status", c),   32'(o_rspStatus), 32'(4'b0101));
         checkOutput($sformatf("bp_stall%0d_data", c),     o_rspData,        0);
      end
      applyStimulus(1, READPC, 0, 0, 0, 0, 0, 1);
      #1;
      checkOutput("bp_release_cmdReady", 32'(o_cmdReady), 1);
      stepCycle();
      checkOutput("bp_second_rspValid", 32'(o_rspValid),  1);
      checkOutput("bp_second_status",   32'(o_rspStatus), 32'(4'b0101));
      checkOutput("bp_second_data",     o_rspData,        32'h40);

      // Leave a response pending while halted, then reset.
      applyStimulus(1, STATUS, 0, 0, 0, 0, 0, 1);
      stepCycle();
      applyStimulus(0, NOP, 0, 0, 0, 0, 0, 0);
      stepCycle();
      checkOutput("pend_rspValid", 32'(o_rspValid), 1);
      checkOutput("pend_data",     o_rspData,       23);
      i_reset = 1'b0;
      stepCycle();
      checkOutput("rst2_halt",     32'(o_halt),      0);
      checkOutput("rst2_halted",   32'(o_halted),    0);
      checkOutput("rst2_rspValid", 32'(o_rspValid),  0);
      checkOutput("rst2_status",   32'(o_rspStatus), 0);
      checkOutput("rst2_data",     o_rspData,        0);
      checkOutput("rst2_cmdReady", 32'(o_cmdReady),  1);
      i_reset = 1'b1;

      // Captured PC and breakpoints are cleared by reset.
      applyStimulus(1, READPC, 0, 0, 0, 0, 0, 1);
      stepCycle();
      checkOutput("post_rst_data",   o_rspData,        0);
      checkOutput("post_rst_status", 32'(o_rspStatus), 0);
      applyStimulus(0, NOP, 0, 0, 1, 32'h80, 30, 1);
      stepCycle();
      applyStimulus(0, NOP, 0, 0, 0, 0, 0, 1);
      stepCycle();
      checkOutput("post_rst_nohit", 32'(o_halt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
